// File: rtl/grid_pkg.sv
// Shared constants and types for the 8x8 grid row scanner.
package grid_pkg;

  localparam int GRID_N = 8;
  localparam int ROW_W  = $clog2(GRID_N);

  typedef logic [GRID_N-1:0]        row_t;
  typedef logic [GRID_N*GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Row r of a grid occupies bits [8r+7:8r]; column c is bit c of that row.
  function automatic row_t grid_row(input grid_t g, input logic [ROW_W-1:0] r);
    return g[int'(r)*GRID_N +: GRID_N];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/row counter pair for the row scanner: counts DWELL cycles per row,
// advances the row on each blank and flags end-of-dwell / end-of-frame.
module scan_timer
  import grid_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_scan,
  input  logic             i_blank,
  output logic [ROW_W-1:0] o_row_next,
  output logic             o_end_dwell,
  output logic             o_end_frame
);

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(GRID_N - 1);

  logic [7:0]       r_dwell;
  logic [7:0]       w_dwell_next;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_next;

  // Outside SCAN/BLANK both counters sit at zero so a fresh scan starts at row 0.
  always_comb begin
    w_dwell_next = '0;
    w_row_next   = '0;
    if (i_scan) begin
      w_row_next = r_row;
      if (r_dwell != DWELL_LAST) begin
        w_dwell_next = r_dwell + 8'd1;
      end
    end else if (i_blank) begin
      w_row_next = r_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else begin
      r_dwell <= w_dwell_next;
      r_row   <= w_row_next;
    end
  end

  assign o_row_next  = w_row_next;
  assign o_end_dwell = i_scan && (r_dwell == DWELL_LAST);
  assign o_end_frame = i_blank && (r_row == ROW_LAST);

endmodule

// File: rtl/grid_scan.sv
// Double-buffered 8x8 grid row scanner: one row per dwell period with a blank
// between rows; a newly offered grid is swapped in only at a frame boundary.
module grid_scan
  import grid_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic [15:0] gen_count,
  output logic        stable,
  output logic        extinct
);

  state_t           r_state;
  state_t           w_state_next;
  grid_t            r_active;
  grid_t            r_pending;
  grid_t            w_active_next;
  logic             r_pend_valid;
  row_t             r_row_sel;
  row_t             w_row_sel_next;
  row_t             r_col_data;
  row_t             w_col_data_next;
  logic             r_frame_done;
  logic             w_frame_done_next;
  logic [15:0]      r_gen_count;
  logic             r_stable;
  logic             r_extinct;
  logic             w_ready;
  logic             w_xfer;
  logic             w_load_idle;
  logic             w_swap;
  logic [ROW_W-1:0] w_row_next;
  logic             w_end_dwell;
  logic             w_end_frame;

  assign w_ready     = (r_state == ST_IDLE) || !r_pend_valid;
  assign w_xfer      = grid_valid && w_ready;
  assign w_load_idle = w_xfer && (r_state == ST_IDLE);
  assign w_swap      = w_end_frame && r_pend_valid;

  scan_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_scan     (r_state == ST_SCAN),
    .i_blank    (r_state == ST_BLANK),
    .o_row_next (w_row_next),
    .o_end_dwell(w_end_dwell),
    .o_end_frame(w_end_frame)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_next = ST_SCAN;
      ST_SCAN:  if (w_end_dwell) w_state_next = ST_BLANK;
      ST_BLANK: w_state_next = ST_SCAN;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so the registered strobes line
  // up with the state they describe rather than trailing it by a cycle.
  always_comb begin
    w_active_next = r_active;
    if (w_load_idle) begin
      w_active_next = grid_in;
    end else if (w_swap) begin
      w_active_next = r_pending;
    end

    w_row_sel_next    = '0;
    w_col_data_next   = '0;
    w_frame_done_next = (w_state_next == ST_BLANK) && (w_row_next == ROW_W'(GRID_N - 1));
    if (w_state_next == ST_SCAN) begin
      w_row_sel_next  = row_t'(1) << w_row_next;
      w_col_data_next = grid_row(w_active_next, w_row_next);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_row_sel    <= '0;
      r_col_data   <= '0;
      r_frame_done <= 1'b0;
      r_gen_count  <= '0;
      r_stable     <= 1'b0;
      r_extinct    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_active     <= w_active_next;
      r_row_sel    <= w_row_sel_next;
      r_col_data   <= w_col_data_next;
      r_frame_done <= w_frame_done_next;

      // A swap needs pending-valid, which holds ready low, so it never
      // coincides with a transfer into the pending buffer.
      if (w_xfer && (r_state != ST_IDLE)) begin
        r_pending    <= grid_in;
        r_pend_valid <= 1'b1;
      end else if (w_swap) begin
        r_pend_valid <= 1'b0;
      end

      if (w_xfer && (r_gen_count != 16'hFFFF)) begin
        r_gen_count <= r_gen_count + 16'd1;
      end

      if (w_load_idle) begin
        r_stable  <= 1'b0;
        r_extinct <= (grid_in == '0);
      end else if (w_swap) begin
        r_stable  <= (r_pending == r_active);
        r_extinct <= (r_pending == '0);
      end
    end
  end

  assign ready      = w_ready;
  assign row_sel    = r_row_sel;
  assign col_data   = r_col_data;
  assign frame_done = r_frame_done;
  assign gen_count  = r_gen_count;
  assign stable     = r_stable;
  assign extinct    = r_extinct;

endmodule

// File: tb/tb_grid_scan.sv
// Self-checking bench for grid_scan: directed table/sequences plus random
// traffic compared each cycle against a frame-position reference model.
module tb_grid_scan;

  localparam int D = 4;
  localparam int P = 8 * (D + 1);
  localparam logic [63:0] G = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] H = 64'hA5A5_5A5A_F00F_0FF0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] grid_in = '0;
  logic        grid_valid = 1'b0;
  logic        ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic [15:0] gen_count;
  logic        stable;
  logic        extinct;

  grid_scan #(.DWELL(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .grid_in   (grid_in),
    .grid_valid(grid_valid),
    .ready     (ready),
    .row_sel   (row_sel),
    .col_data  (col_data),
    .frame_done(frame_done),
    .gen_count (gen_count),
    .stable    (stable),
    .extinct   (extinct)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: position within the frame is plain arithmetic on the
  // number of cycles since scanning started.
  bit          m_idle = 1'b1;
  int          m_t = 0;
  logic [63:0] m_active = '0;
  logic [63:0] m_pending = '0;
  bit          m_pvalid = 1'b0;
  logic [15:0] m_count = '0;
  bit          m_stable = 1'b0;
  bit          m_extinct = 1'b0;

  typedef struct {
    int         row;
    int         off;
    logic [7:0] exp_sel;
    logic [7:0] exp_col;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit model_ready();
    return m_idle || !m_pvalid;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_t = 0; m_active = '0; m_pending = '0; m_pvalid = 1'b0;
    m_count = '0; m_stable = 1'b0; m_extinct = 1'b0;
  endtask

  task automatic check_outputs();
    logic [7:0] e_sel;
    logic [7:0] e_col;
    bit e_fd;
    int p, r, s;
    e_sel = '0; e_col = '0; e_fd = 1'b0;
    if (!m_idle) begin
      p = m_t % P;
      r = p / (D + 1);
      s = p % (D + 1);
      if (s < D) begin
        e_sel = 8'(1 << r);
        e_col = m_active[8*r +: 8];
      end
      e_fd = (p == P - 1);
    end
    chk("row_sel", 64'(row_sel), 64'(e_sel));
    chk("col_data", 64'(col_data), 64'(e_col));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("gen_count", 64'(gen_count), 64'(m_count));
    chk("stable", 64'(stable), 64'(m_stable));
    chk("extinct", 64'(extinct), 64'(m_extinct));
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic tick();
    bit xfer;
    logic [63:0] g;
    chk("ready", 64'(ready), 64'(model_ready()));
    xfer = grid_valid && model_ready();
    g = grid_in;
    @(posedge clk);
    #1;
    if (m_idle) begin
      if (xfer) begin
        m_idle = 1'b0; m_t = 0; m_active = g; m_stable = 1'b0; m_extinct = (g == 64'h0);
      end
    end else begin
      if ((m_t % P) == P - 1 && m_pvalid) begin
        m_stable = (m_pending == m_active);
        m_extinct = (m_pending == 64'h0);
        m_active = m_pending;
        m_pvalid = 1'b0;
      end
      if (xfer) begin
        m_pending = g; m_pvalid = 1'b1;
      end
      m_t++;
    end
    if (xfer && m_count != 16'hFFFF) m_count++;
    check_outputs();
  endtask

  task automatic wait_phase(input int ph);
    int guard = 0;
    while ((m_idle || (m_t % P) != ph) && guard < 3 * P) begin
      tick();
      guard++;
    end
    if (guard >= 3 * P) begin
      n_total++;
      $display("FAIL phase_wait: got no phase %0d within %0d cycles", ph, 3 * P);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_row_sel", 64'(row_sel), 64'h0);
    chk("rst_col_data", 64'(col_data), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_gen_count", 64'(gen_count), 64'h0);
    chk("rst_stable", 64'(stable), 64'h0);
    chk("rst_extinct", 64'(extinct), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("ready_after_reset", 64'(ready), 64'h1);
  endtask

  task automatic send(input logic [63:0] g);
    grid_valid = 1'b1; grid_in = g;
    tick();
    grid_valid = 1'b0;
  endtask

  initial begin
    int fd_n, fd_first, fd_second;
    logic [63:0] last_g;

    tbl[0]  = '{0, 0,     8'h01, 8'h28};
    tbl[1]  = '{0, D - 1, 8'h01, 8'h28};
    tbl[2]  = '{0, D,     8'h00, 8'h00};
    tbl[3]  = '{1, 0,     8'h02, 8'h3C};
    tbl[4]  = '{2, 0,     8'h04, 8'h34};
    tbl[5]  = '{3, 0,     8'h08, 8'h00};
    tbl[6]  = '{4, 0,     8'h10, 8'h24};
    tbl[7]  = '{5, 0,     8'h20, 8'h64};
    tbl[8]  = '{6, 0,     8'h40, 8'h12};
    tbl[9]  = '{7, 0,     8'h80, 8'h04};
    tbl[10] = '{7, D - 1, 8'h80, 8'h04};
    tbl[11] = '{7, D,     8'h00, 8'h00};

    async_reset();

    // First frame after a load from IDLE.
    send(G);
    chk("gen_first", 64'(gen_count), 64'h1);
    chk("stable_first", 64'(stable), 64'h0);
    chk("extinct_first", 64'(extinct), 64'h0);
    for (int i = 0; i < 12; i++) begin
      wait_phase(tbl[i].row * (D + 1) + tbl[i].off);
      chk($sformatf("tbl%0d_row_sel", i), 64'(row_sel), 64'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_col_data", i), 64'(col_data), 64'(tbl[i].exp_col));
    end
    chk("fd_at_boundary", 64'(frame_done), 64'h1);

    // Idle rescans: frame_done every P cycles.
    fd_n = 0; fd_first = 0; fd_second = 0;
    for (int c = 1; c <= 2 * P; c++) begin
      tick();
      if (frame_done) begin
        fd_n++;
        if (fd_n == 1) fd_first = c;
        if (fd_n == 2) fd_second = c;
      end
    end
    chk("fd_count", 64'(fd_n), 64'd2);
    chk("fd_period", 64'(fd_second - fd_first), 64'(P));

    // Same grid mid-frame, then ignored offers while ready is low.
    wait_phase(10);
    send(G);
    chk("ready_low", 64'(ready), 64'h0);
    grid_valid = 1'b1; grid_in = 64'hDEAD_BEEF_0000_FFFF;
    for (int i = 0; i < 5; i++) tick();
    grid_valid = 1'b0;
    wait_phase(0);
    chk("stable_after_same", 64'(stable), 64'h1);
    chk("gen_after_same", 64'(gen_count), 64'h2);
    chk("col_after_same", 64'(col_data), 64'h28);

    // All-zero grid.
    wait_phase(3);
    send(64'h0);
    wait_phase(0);
    chk("extinct_set", 64'(extinct), 64'h1);
    chk("stable_clear", 64'(stable), 64'h0);
    wait_phase(2 * (D + 1));
    chk("zero_row_sel", 64'(row_sel), 64'h04);
    chk("zero_col", 64'(col_data), 64'h0);

    // Offer exactly in the boundary cycle: shown one frame later.
    wait_phase(P - 1);
    chk("boundary_ready", 64'(ready), 64'h1);
    send(H);
    chk("boundary_not_yet", 64'(col_data), 64'h0);
    wait_phase(P - 1);
    tick();
    chk("boundary_shown", 64'(col_data), 64'hF0);
    chk("boundary_extinct", 64'(extinct), 64'h0);

    // Random traffic.
    last_g = H;
    for (int i = 0; i < 400; i++) begin
      grid_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: grid_in = 64'h0;
        1: grid_in = last_g;
        default: grid_in = {$urandom, $urandom};
      endcase
      if (grid_valid && model_ready()) last_g = grid_in;
      tick();
    end
    grid_valid = 1'b0;

    // Reset during row 5.
    wait_phase(5 * (D + 1) + 1);
    async_reset();
    tick();

    // Saturation of gen_count near the top of its range.
    send(G);
    force dut.r_gen_count = 16'hFFFD;
    #1;
    release dut.r_gen_count;
    m_count = 16'hFFFD;
    grid_valid = 1'b1;
    for (int i = 0; i < 4 * P; i++) begin
      grid_in = {$urandom, $urandom};
      tick();
    end
    grid_valid = 1'b0;
    chk("gen_saturated", 64'(gen_count), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
